// File: rtl/des_pkg.sv
// des_pkg -- shared DES constants for the S-box substitution stage.
//
// Contents:
//   DES_EXP_W / DES_WORD_W  expanded half-block width (48) and word width (32)
//   SBOX_IN_W / SBOX_OUT_W  S-box chunk width (6) and value width (4)
//   sbox_state_e            IDLE / RUN / DONE encoding of the substitution FSM
//   SBOX_TABLE              the eight 4x16 DES S-boxes (8 x 64 x 4 bits)
//   fips_nibble()           turns an S-box value into DataOut bit order
package des_pkg;

  localparam int DES_EXP_W  = 48;
  localparam int DES_WORD_W = 32;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int NUM_SBOX   = DES_EXP_W / SBOX_IN_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sbox_state_e;

  // Entry {box, row} holds one 16-entry row; column 0 is the most significant
  // nibble so a row reads left to right exactly as printed in FIPS 46-3.
  localparam logic [63:0] SBOX_TABLE [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // DataOut keeps FIPS bit 1 at index 0, so the value's MSB lands on the
  // lowest index of its nibble.
  function automatic logic [SBOX_OUT_W-1:0] fips_nibble(input logic [SBOX_OUT_W-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/sbox_substitution_if.sv
// sbox_substitution_if -- input and output streams of the S-box stage.
//
// Handshake: a word moves on a rising edge when valid and ready are both high
// in that cycle. A producer holding valid keeps its data stable until the
// transfer; ready may depend combinationally on the opposite side's ready.
//   DataIn/InValid/InReady     expanded R XOR subkey toward the S-box stage
//   DataOut/OutValid/OutReady  substituted word toward the P-permutation
// Modports: master = surrounding datapath, slave = sbox_substitution.
interface sbox_substitution_if;
  import des_pkg::*;

  logic [DES_EXP_W-1:0]  DataIn;
  logic                  InValid;
  logic                  InReady;
  logic [DES_WORD_W-1:0] DataOut;
  logic                  OutValid;
  logic                  OutReady;

  modport master (
    output DataIn, InValid, OutReady,
    input  InReady, DataOut, OutValid
  );

  modport slave (
    input  DataIn, InValid, OutReady,
    output InReady, DataOut, OutValid
  );

endinterface

// File: rtl/sbox_lookup.sv
// sbox_lookup -- combinational lookup into one of the eight DES S-boxes.
//
// Ports:
//   box_idx  in   3  S-box number minus one (0 = S1)
//   chunk    in   6  chunk with FIPS bit 1 at index 0
//   value    out  4  raw S-box value, MSB = first output bit
module sbox_lookup
  import des_pkg::*;
(
  input  logic [2:0]            box_idx,
  input  logic [SBOX_IN_W-1:0]  chunk,
  output logic [SBOX_OUT_W-1:0] value
);

  logic [1:0]  row;
  logic [3:0]  col;
  logic [63:0] row_bits;
  logic [63:0] shifted;

  always_comb begin
    // Outer bits pick the row, inner four the column (FIPS b1b6 / b2..b5).
    row      = {chunk[0], chunk[5]};
    col      = {chunk[1], chunk[2], chunk[3], chunk[4]};
    row_bits = SBOX_TABLE[{box_idx, row}];
    // Column 0 sits in the top nibble; shift the wanted one up there.
    shifted  = row_bits << {col, 2'b00};
    value    = shifted[63:60];
  end

endmodule

// File: rtl/sbox_substitution.sv
// sbox_substitution -- DES S-box substitution stage (48-bit in, 32-bit out).
//
// Ports:
//   Clk        in   1   rising-edge clock
//   Reset      in   1   synchronous active-high reset
//   bus        slave    DataIn/InValid/InReady, DataOut/OutValid/OutReady
//   Busy       out  1   high while the serial walk is in RUN
//   state_dbg  out  2   current FSM state
//
// Default build: one sbox_lookup walks the eight chunks over eight RUN
// cycles. Defining SBOX_PARALLEL_EN instantiates eight lookups, skips RUN and
// loads the result on the input-transfer edge; Busy then stays low.
module sbox_substitution
  import des_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  sbox_substitution_if.slave bus,
  output logic               Busy,
  output sbox_state_e        state_dbg
);

  sbox_state_e           state_q, state_d;
  logic [DES_WORD_W-1:0] dout_q, dout_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.DataOut = dout_q;
  assign state_dbg   = state_q;

`ifdef SBOX_PARALLEL_EN

  logic [DES_WORD_W-1:0] par_word;

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_box
    logic [SBOX_OUT_W-1:0] val;
    sbox_lookup u_lookup (
      .box_idx (3'(g)),
      .chunk   (bus.DataIn[g*SBOX_IN_W +: SBOX_IN_W]),
      .value   (val)
    );
    assign par_word[g*SBOX_OUT_W +: SBOX_OUT_W] = fips_nibble(val);
  end

  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    bus.InReady  = 1'b0;
    bus.OutValid = 1'b0;
    Busy         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.InReady = 1'b1;
        if (bus.InValid) begin
          dout_d  = par_word;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.OutValid = 1'b1;
        bus.InReady  = bus.OutReady;
        if (bus.OutReady) begin
          if (bus.InValid) dout_d  = par_word;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`else

  logic [2:0]            cnt_q, cnt_d;
  logic [DES_EXP_W-1:0]  din_q, din_d;
  logic [SBOX_OUT_W-1:0] sbox_val;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
      din_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      din_q <= din_d;
    end
  end

  // The captured word shifts right one chunk per RUN cycle, so the current
  // chunk is always in the low six bits and box cnt_q+1 is being evaluated.
  sbox_lookup u_lookup (
    .box_idx (cnt_q),
    .chunk   (din_q[SBOX_IN_W-1:0]),
    .value   (sbox_val)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    din_d        = din_q;
    dout_d       = dout_q;
    bus.InReady  = 1'b0;
    bus.OutValid = 1'b0;
    Busy         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.InReady = 1'b1;
        if (bus.InValid) begin
          din_d   = bus.DataIn;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        Busy  = 1'b1;
        din_d = din_q >> SBOX_IN_W;
        // Results enter at the top and shift down; after eight cycles S1
        // sits in DataOut[3:0] and S8 in DataOut[31:28].
        dout_d = {fips_nibble(sbox_val), dout_q[DES_WORD_W-1:SBOX_OUT_W]};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.OutValid = 1'b1;
        bus.InReady  = bus.OutReady;
        if (bus.OutReady) begin
          if (bus.InValid) begin
            din_d   = bus.DataIn;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`endif

endmodule

// File: tb/tb_sbox_substitution.sv
// tb_sbox_substitution -- self-checking bench for sbox_substitution.
// Expected words come from a FIPS-style S-box model held here and from
// published known-answer vectors.
module tb_sbox_substitution;

`ifdef SBOX_PARALLEL_EN
  localparam int LAT    = 1;
  localparam int PERIOD = 1;
  localparam bit SERIAL = 1'b0;
`else
  localparam int LAT    = 9;
  localparam int PERIOD = 9;
  localparam bit SERIAL = 1'b1;
`endif

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 Busy;
  des_pkg::sbox_state_e state_dbg;

  sbox_substitution_if bus ();

  sbox_substitution dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .Busy      (Busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  int sb [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7},  '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0},  '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10},  '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15},  '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8},  '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7},  '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15},  '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4},  '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9},  '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14},  '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11},  '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6},  '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1},  '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2},  '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7},  '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8},  '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  // FIPS bit n of the input is din[n-1]; output FIPS bit n is result[n-1].
  function automatic logic [31:0] ref_sub(input logic [47:0] din);
    logic [31:0] r;
    logic [3:0]  v;
    int          row, col;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      row = 2 * int'(din[6*k]) + int'(din[6*k+5]);
      col = 8 * int'(din[6*k+1]) + 4 * int'(din[6*k+2])
          + 2 * int'(din[6*k+3]) + int'(din[6*k+4]);
      v = 4'(sb[k][row][col]);
      for (int j = 0; j < 4; j++) r[4*k+j] = v[3-j];
    end
    return r;
  endfunction

  // Converts a word written MSB-first in FIPS order into bus bit order.
  function automatic logic [47:0] fips48(input logic [47:0] s);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = s[47-i];
    return r;
  endfunction

  function automatic logic [31:0] fips32(input logic [31:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = s[31-i];
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom_range(0, 65535)), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Presents one word, then counts edges (the capture edge is edge 1) until
  // OutValid; DataIn is scrambled while the word is in flight.
  task automatic run_word(input logic [47:0] din, output int lat, output int busy_err);
    bus.DataIn   = din;
    bus.InValid  = 1'b1;
    bus.OutReady = 1'b0;
    busy_err     = 0;
    step();
    lat          = 1;
    bus.InValid  = 1'b0;
    while (!bus.OutValid && lat < 40) begin
      if (Busy !== SERIAL) busy_err++;
      bus.DataIn = rand48();
      step();
      lat++;
    end
    if (Busy !== 1'b0) busy_err++;
  endtask

  task automatic consume();
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    step();
    bus.OutReady = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset        = 1'b1;
    bus.DataIn   = '0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    step();
    step();
    Reset = 1'b0;
    n_checks++;
    if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.InReady); end
    n_checks++;
    if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.OutValid); end
    n_checks++;
    if (bus.DataOut !== 32'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", bus.DataOut); end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++;
    if (state_dbg !== des_pkg::ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    // Reset wins over a simultaneous input transfer.
    Reset       = 1'b1;
    bus.InValid = 1'b1;
    bus.DataIn  = rand48();
    step();
    Reset       = 1'b0;
    bus.InValid = 1'b0;
    n_checks++;
    if ({bus.OutValid, Busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_priority: got valid/busy %b want 00", {bus.OutValid, Busy});
    end
  endtask

  task automatic test_known_answers();
    logic [47:0] kin  [3];
    logic [31:0] kexp [3];
    int lat, berr;
    kin[0]  = '0;
    kexp[0] = fips32(32'hEFA72C4D);
    kin[1]  = '1;
    kexp[1] = fips32(32'hD9CE3DCB);
    kin[2]  = fips48(48'b011000_010001_011110_111010_100001_100110_010100_100111);
    kexp[2] = fips32(32'b0101_1100_1000_0010_1011_0101_1001_0111);
    for (int i = 0; i < 3; i++) begin
      run_word(kin[i], lat, berr);
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL kat%0d_latency: got %0d want %0d", i, lat, LAT); end
      n_checks++;
      if (bus.DataOut !== kexp[i]) begin n_fail++; $display("FAIL kat%0d_data: got %h want %h", i, bus.DataOut, kexp[i]); end
      n_checks++;
      if (berr != 0) begin n_fail++; $display("FAIL kat%0d_busy: %0d wrong Busy samples, want 0", i, berr); end
      consume();
    end
  endtask

  // Every box sees the same chunk value, so 64 words visit all 512 entries.
  task automatic test_table_sweep();
    logic [47:0] din;
    logic [5:0]  c;
    int lat, berr;
    for (int i = 0; i < 64; i++) begin
      c   = 6'(i);
      din = {8{c}};
      run_word(din, lat, berr);
      n_checks++;
      if (bus.DataOut !== ref_sub(din)) begin
        n_fail++; $display("FAIL sweep%0d_data: got %h want %h", i, bus.DataOut, ref_sub(din));
      end
      consume();
    end
  endtask

  task automatic test_random_words();
    logic [47:0] din;
    int lat, berr;
    for (int i = 0; i < 12; i++) begin
      din = rand48();
      run_word(din, lat, berr);
      n_checks++;
      if (lat != LAT || bus.DataOut !== ref_sub(din)) begin
        n_fail++; $display("FAIL rand%0d: got lat %0d data %h want lat %0d data %h", i, lat, bus.DataOut, LAT, ref_sub(din));
      end
      consume();
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] din, din2;
    logic [31:0] held;
    int lat, berr, stall_err;
    din = rand48();
    run_word(din, lat, berr);
    held      = bus.DataOut;
    stall_err = 0;
    n_checks++;
    if (held !== ref_sub(din)) begin n_fail++; $display("FAIL bp_first_data: got %h want %h", held, ref_sub(din)); end
    for (int i = 0; i < 20; i++) begin
      bus.InValid = 1'($urandom_range(0, 1));
      bus.DataIn  = rand48();
      #1;
      if (bus.InReady !== 1'b0) stall_err++;
      step();
      if (bus.OutValid !== 1'b1 || bus.DataOut !== held) stall_err++;
    end
    n_checks++;
    if (stall_err != 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable samples, want 0", stall_err); end
    din2         = rand48();
    bus.DataIn   = din2;
    bus.InValid  = 1'b1;
    bus.OutReady = 1'b1;
    #1;
    n_checks++;
    if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.InReady); end
    step();
    lat          = 1;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    while (!bus.OutValid && lat < 40) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat != LAT || bus.DataOut !== ref_sub(din2)) begin
      n_fail++; $display("FAIL bp_second: got lat %0d data %h want lat %0d data %h", lat, bus.DataOut, LAT, ref_sub(din2));
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int lat, berr, stray;
    bus.DataIn  = rand48();
    bus.InValid = 1'b1;
    step();
    bus.InValid = 1'b0;
    repeat (4) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_checks++;
    if (bus.OutValid !== 1'b0 || bus.DataOut !== 32'h0 || bus.InReady !== 1'b1 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: got valid %b data %h ready %b busy %b want 0 0 1 0",
                         bus.OutValid, bus.DataOut, bus.InReady, Busy);
    end
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.OutValid !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL midrun_no_partial: %0d OutValid cycles want 0", stray); end
    begin
      logic [47:0] din;
      din = rand48();
      run_word(din, lat, berr);
      n_checks++;
      if (lat != LAT || bus.DataOut !== ref_sub(din)) begin
        n_fail++; $display("FAIL midrun_next: got lat %0d data %h want lat %0d data %h", lat, bus.DataOut, LAT, ref_sub(din));
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, last_out;
    logic [47:0] cur;
    logic [31:0] e;
    logic acc;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; last_out = -1;
    cur          = rand48();
    bus.DataIn   = cur;
    bus.InValid  = 1'b1;
    bus.OutReady = 1'b1;
    while (got < 5 && cyc < 200) begin
      #1;
      if (bus.OutValid && bus.OutReady) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: got %h with empty queue", bus.DataOut);
        end else begin
          e = exp_q.pop_front();
          if (bus.DataOut !== e) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", got, bus.DataOut, e); end
        end
        if (last_out >= 0) begin
          n_checks++;
          if (cyc - last_out != PERIOD) begin
            n_fail++; $display("FAIL b2b_gap%0d: got %0d want %0d", got, cyc - last_out, PERIOD);
          end
        end
        last_out = cyc;
        got++;
      end
      acc = bus.InValid && bus.InReady;
      if (acc) begin
        exp_q.push_back(ref_sub(cur));
        sent++;
      end
      step();
      cyc++;
      if (acc) begin
        cur         = rand48();
        bus.DataIn  = cur;
        bus.InValid = (sent < 5);
      end
    end
    n_checks++;
    if (got != 5 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d words, %0d pending, want 5 and 0", got, exp_q.size());
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_random_stream();
    int sent, got, cyc;
    logic [47:0] cur;
    logic [31:0] e;
    logic acc;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    cur          = '0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    while (got < 25 && cyc < 3000) begin
      if (!bus.InValid && sent < 25 && $urandom_range(0, 2) != 0) begin
        cur         = rand48();
        bus.DataIn  = cur;
        bus.InValid = 1'b1;
      end
      bus.OutReady = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.OutValid && bus.OutReady) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_unexpected: got %h with empty queue", bus.DataOut);
        end else begin
          e = exp_q.pop_front();
          if (bus.DataOut !== e) begin n_fail++; $display("FAIL stream_data%0d: got %h want %h", got, bus.DataOut, e); end
        end
        got++;
      end
      acc = bus.InValid && bus.InReady;
      if (acc) begin
        exp_q.push_back(ref_sub(cur));
        sent++;
      end
      step();
      cyc++;
      if (acc) bus.InValid = 1'b0;
    end
    n_checks++;
    if (got != 25 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL stream_count: got %0d words, %0d pending, want 25 and 0", got, exp_q.size());
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_known_answers();
    test_table_sweep();
    test_random_words();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
